spi_tx_buffer: RTL and testbench

- SPI-slave receive path for the TX direction: the Beagle host (MCSPI3 master, CS0) writes 16-bit DAC sample words; the block buffers them and hands one 14-bit sample per tx_strobe to the tx_a DAC datapath.
- During every transfer it returns a status word on SOMI.
- All SPI pins are oversampled in the master_clk domain; there is no second clock.
- It is the counterpart of the host-bound rx_buffer.

---
 rtl/spi_tx_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_spi_tx_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_buffer.sv
// SPI-slave sample receiver feeding the tx_a DAC datapath.
// Oversamples the host SPI pins in master_clk, buffers words, returns status on SOMI.
`timescale 1ns/1ps
module spi_tx_buffer #(
    parameter int WIDTH      = 14,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  master_clk,
    input  logic                  reset_n,
    input  logic                  spi_clk,
    input  logic                  spi_simo,
    input  logic                  spi_cs_n,
    output logic                  spi_somi,
    input  logic                  enable,
    input  logic                  tx_strobe,
    output logic [WIDTH-1:0]      tx_data,
    output logic                  tx_valid,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    logic [2:0]            r_clk_sync;
    logic [1:0]            r_simo_sync;
    logic [2:0]            r_cs_sync;

    state_t                r_state;
    logic [3:0]            r_bit_cnt;
    logic [WIDTH-1:0]      r_rx_sr;
    logic                  r_word_done;
    logic [14:0]           r_tx_sr;
    logic                  r_somi;
    logic                  r_skip;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_fill;
    logic [WIDTH-1:0]      r_tx_data;
    logic                  r_tx_valid;
    logic                  r_overrun;
    logic                  r_underrun;

    logic                  w_clk_rise;
    logic                  w_clk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_simo;
    logic [15:0]           w_status;
    logic                  w_cap;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_under;

    assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
    assign w_clk_fall = ~r_clk_sync[1] & r_clk_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_simo     = r_simo_sync[1];

    assign w_status = {r_overrun, r_underrun,
                       {(14 - DEPTH_LOG2 - 1){1'b0}}, r_fill};

    assign w_pop   = tx_strobe & enable & (r_fill != '0);
    assign w_push  = r_word_done & enable & ((r_fill != FULL) | w_pop);
    assign w_drop  = r_word_done & enable & ~w_push;
    assign w_under = tx_strobe & enable & (r_fill == '0);

    // Status is sampled (and flags cleared) at CS assertion and at each word end.
    always_comb begin
        w_cap = 1'b0;
        if (r_state == S_IDLE)
            w_cap = w_cs_fall;
        else if (!w_cs_rise && w_clk_rise && r_bit_cnt == 4'd15)
            w_cap = 1'b1;
    end

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 3'b000;
            r_simo_sync <= 2'b00;
            r_cs_sync   <= 3'b111;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], spi_clk};
            r_simo_sync <= {r_simo_sync[0], spi_simo};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
        end
    end

    // Receive/transmit shift FSM; word end reloads status, skips the next fall.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_rx_sr     <= '0;
            r_word_done <= 1'b0;
            r_tx_sr     <= '0;
            r_somi      <= 1'b0;
            r_skip      <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_somi <= 1'b0;
                    if (w_cs_fall) begin
                        r_state   <= S_SHIFT;
                        r_bit_cnt <= 4'd0;
                        r_tx_sr   <= w_status[14:0];
                        r_somi    <= w_status[15];
                        r_skip    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= 4'd0;
                        r_somi    <= 1'b0;
                        r_skip    <= 1'b0;
                    end else if (w_clk_rise) begin
                        r_rx_sr <= {r_rx_sr[WIDTH-2:0], w_simo};
                        if (r_bit_cnt == 4'd15) begin
                            r_bit_cnt   <= 4'd0;
                            r_word_done <= enable;
                            r_tx_sr     <= w_status[14:0];
                            r_somi      <= w_status[15];
                            r_skip      <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (w_clk_fall) begin
                        if (r_skip) begin
                            r_skip <= 1'b0;
                        end else begin
                            r_tx_sr <= {r_tx_sr[13:0], 1'b0};
                            r_somi  <= r_tx_sr[14];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sample storage; pop reads the old head before a same-cycle write.
    always_ff @(posedge master_clk) begin
        if (w_push)
            r_mem[r_wp] <= r_rx_sr;
    end

    // FIFO pointers, occupancy and the registered DAC output.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fill     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (!enable) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fill     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rp];
                r_rp      <= r_rp + 1'b1;
            end else if (tx_strobe) begin
                r_tx_data <= '0;
            end
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_push && !w_pop)
                r_fill <= r_fill + 1'b1;
            else if (w_pop && !w_push)
                r_fill <= r_fill - 1'b1;
        end
    end

    // Sticky error flags; a set in the capture cycle wins over the clear.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= (r_overrun & ~w_cap) | w_drop;
            r_underrun <= (r_underrun & ~w_cap) | w_under;
        end
    end

    assign spi_somi = r_somi;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign fill     = r_fill;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_tx_buffer.sv
// Self-checking bench for spi_tx_buffer.
// Directed table, corner sequences, then random traffic against a queue model.
`timescale 1ns/1ps
module tb_spi_tx_buffer;

    localparam int WIDTH = 14;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic             master_clk = 1'b0;
    logic             reset_n    = 1'b0;
    logic             spi_clk    = 1'b0;
    logic             spi_simo   = 1'b0;
    logic             spi_cs_n   = 1'b1;
    logic             enable     = 1'b1;
    logic             tx_strobe  = 1'b0;
    logic             spi_somi;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic [DL:0]      fill;
    logic             overrun;
    logic             underrun;

    always #5 master_clk = ~master_clk;

    spi_tx_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .spi_clk    (spi_clk),
        .spi_simo   (spi_simo),
        .spi_cs_n   (spi_cs_n),
        .spi_somi   (spi_somi),
        .enable     (enable),
        .tx_strobe  (tx_strobe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .fill       (fill),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] word;
        logic [13:0] exp;
    } vec_t;

    vec_t vt[8];

    // reference model state
    int          q[$];
    bit          m_ovr;
    bit          m_und;
    logic [13:0] m_tx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    task automatic spi_bits(input logic [15:0] w, input int n,
                            input bit stb, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_simo = w[15-i];
            wait_clks(4);
            rx[15-i] = spi_somi;
            spi_clk = 1'b1;
            if (stb && i == n - 1) begin
                wait_clks(3);
                tx_strobe = 1'b1;
                wait_clks(1);
                tx_strobe = 1'b0;
            end else begin
                wait_clks(4);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [15:0] w, input int n,
                            input bit stb, output logic [15:0] rx);
        spi_cs_n = 1'b0;
        spi_bits(w, n, stb, rx);
        wait_clks(4);
        spi_cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic strobe();
        tx_strobe = 1'b1;
        wait_clks(1);
        tx_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(3);
        q.delete();
        m_ovr = 0;
        m_und = 0;
        m_tx  = '0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rx;
        logic [15:0] exp_st;
        logic [15:0] w;
        int          op;
        bit          exp_v;

        vt[0] = '{16'h1ABC, 14'h1ABC};
        vt[1] = '{16'hFFFF, 14'h3FFF};
        vt[2] = '{16'hC001, 14'h0001};
        vt[3] = '{16'h8000, 14'h0000};
        vt[4] = '{16'h4000, 14'h0000};
        vt[5] = '{16'h3FFF, 14'h3FFF};
        vt[6] = '{16'h2AAA, 14'h2AAA};
        vt[7] = '{16'hD555, 14'h1555};

        // reset state
        wait_clks(3);
        chk("rst fill", fill, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst overrun", overrun, 0);
        chk("rst underrun", underrun, 0);
        chk("rst somi", spi_somi, 0);
        reset_n = 1'b1;
        wait_clks(3);

        // table: one word, one strobe, 14 LSBs out
        for (int i = 0; i < 8; i++) begin
            spi_xfer(vt[i].word, 16, 1'b0, rx);
            chk("tbl status", rx, 16'h0000);
            chk("tbl fill1", fill, 1);
            strobe();
            chk("tbl tx_data", tx_data, vt[i].exp);
            chk("tbl tx_valid", tx_valid, 1);
            chk("tbl fill0", fill, 0);
        end
        wait_clks(1);
        chk("valid pulse", tx_valid, 0);

        // underrun on empty
        strobe();
        chk("und tx_data", tx_data, 0);
        chk("und tx_valid", tx_valid, 0);
        strobe();
        chk("und flag", underrun, 1);
        spi_xfer(16'h0000, 16, 1'b0, rx);
        chk("und status", rx, 16'h4000);
        chk("und cleared", underrun, 0);
        chk("und fill", fill, 1);
        strobe();

        // 17 words into a 16-deep FIFO
        for (int i = 0; i < 17; i++)
            spi_xfer(16'(i), 16, 1'b0, rx);
        chk("ovr fill", fill, 16);
        chk("ovr flag", overrun, 1);
        for (int i = 0; i < 16; i++) begin
            strobe();
            chk("ovr order", tx_data, i);
        end
        chk("ovr drained", fill, 0);
        spi_xfer(16'h0AAA, 16, 1'b0, rx);
        chk("ovr status", rx, 16'h8000);
        chk("ovr cleared", overrun, 0);
        strobe();
        chk("ovr next", tx_data, 14'h0AAA);

        // full FIFO, strobe in the push cycle
        for (int i = 0; i < 16; i++)
            spi_xfer(16'h0100 + 16'(i), 16, 1'b0, rx);
        chk("full fill", fill, 16);
        spi_xfer(16'h0200, 16, 1'b1, rx);
        chk("full status", rx, 16'h0010);
        chk("full fill kept", fill, 16);
        chk("full no ovr", overrun, 0);
        chk("full head", tx_data, 14'h0100);
        for (int i = 1; i < 17; i++) begin
            strobe();
            chk("full order", tx_data, (i < 16) ? 32'h100 + i : 32'h200);
        end

        // partial word discarded
        spi_xfer(16'hFFFF, 9, 1'b0, rx);
        chk("part fill0", fill, 0);
        spi_xfer(16'h0123, 16, 1'b0, rx);
        chk("part fill1", fill, 1);
        strobe();
        chk("part data", tx_data, 14'h0123);

        // enable low: discard and flush
        enable = 1'b0;
        wait_clks(2);
        spi_xfer(16'h0777, 16, 1'b0, rx);
        chk("dis fill", fill, 0);
        enable = 1'b1;
        wait_clks(2);
        spi_xfer(16'h0011, 16, 1'b0, rx);
        spi_xfer(16'h0022, 16, 1'b0, rx);
        chk("en fill", fill, 2);
        strobe();
        chk("en data", tx_data, 14'h0011);
        enable = 1'b0;
        wait_clks(2);
        chk("flush fill", fill, 0);
        chk("flush data", tx_data, 0);
        enable = 1'b1;
        wait_clks(2);

        // reset mid-word
        spi_xfer(16'h0033, 16, 1'b0, rx);
        strobe();
        strobe();
        spi_xfer(16'h0044, 16, 1'b0, rx);
        spi_cs_n = 1'b0;
        spi_bits(16'hA5A5, 8, 1'b0, rx);
        reset_n = 1'b0;
        #1;
        chk("mid fill", fill, 0);
        chk("mid tx_data", tx_data, 0);
        chk("mid overrun", overrun, 0);
        chk("mid underrun", underrun, 0);
        chk("mid somi", spi_somi, 0);
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(4);
        spi_cs_n = 1'b1;
        wait_clks(6);
        spi_xfer(16'h0055, 16, 1'b0, rx);
        chk("post fill", fill, 1);
        strobe();
        chk("post data", tx_data, 14'h0055);

        // random traffic against the queue model
        do_reset();
        for (int it = 0; it < 70; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                w = 16'($urandom);
                exp_st = {m_ovr, m_und, 9'b0, 5'(q.size())};
                m_ovr = 0;
                m_und = 0;
                spi_xfer(w, 16, 1'b0, rx);
                chk("rnd status", rx, exp_st);
                if (q.size() < DEPTH)
                    q.push_back(int'(w) & 32'h3FFF);
                else
                    m_ovr = 1;
                chk("rnd fill", fill, q.size());
                chk("rnd overrun", overrun, m_ovr);
            end else if (op <= 8) begin
                strobe();
                if (q.size() > 0) begin
                    m_tx  = 14'(q.pop_front());
                    exp_v = 1;
                end else begin
                    m_tx  = '0;
                    exp_v = 0;
                    m_und = 1;
                end
                chk("rnd valid", tx_valid, exp_v);
                chk("rnd data", tx_data, m_tx);
                chk("rnd fill", fill, q.size());
                chk("rnd underrun", underrun, m_und);
            end else begin
                enable = 1'b0;
                wait_clks(2);
                enable = 1'b1;
                wait_clks(1);
                q.delete();
                m_tx = '0;
                chk("rnd flush fill", fill, 0);
                chk("rnd flush data", tx_data, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
